// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS Avalon-MM bus/memory unit.
// Imported by the interface, the lane aligner and the top.
package mips_bus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      DONE = 2'd2
   } bus_state_t;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;

   localparam int ARB_FIXED = 0;
   localparam int ARB_ALT   = 1;

endpackage

// File: rtl/mips_bus_mem_unit_if.sv
// Avalon-MM master-side bus bundle between the memory unit and the system.
// valid/ready: read/write act as valid and stay stable until a cycle with waitrequest=0 completes the beat.
interface mips_bus_mem_unit_if #(
   parameter int ADDR_W = 32
) ();
   logic [ADDR_W-1:0] address;
   logic              read;
   logic              write;
   logic              waitrequest;
   logic [31:0]       writedata;
   logic [3:0]        byteenable;
   logic [31:0]       readdata;

   modport master (
      output address, read, write, writedata, byteenable,
      input  waitrequest, readdata
   );

   modport slave (
      input  address, read, write, writedata, byteenable,
      output waitrequest, readdata
   );
endinterface

// File: rtl/mips_bus_lane_align.sv
// Little-endian lane logic: byte enables, replicated store data,
// load lane extraction with sign/zero extension, and misalignment detection.
module mips_bus_lane_align
   import mips_bus_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  a,
   input  logic        sign_ext,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata_bus,
   output logic [3:0]  byteenable,
   output logic [31:0] writedata,
   output logic [31:0] rdata_ext,
   output logic        misaligned
);

   logic [31:0] shifted;
   logic [7:0]  sel_b;
   logic [15:0] sel_h;

   assign shifted = rdata_bus >> {a, 3'b000};
   assign sel_b   = shifted[7:0];
   assign sel_h   = a[1] ? rdata_bus[31:16] : rdata_bus[15:0];

   always_comb begin
      byteenable = 4'b0000;
      writedata  = 32'd0;
      rdata_ext  = 32'd0;
      misaligned = 1'b0;
      case (size)
         SIZE_B: begin
            byteenable = 4'b0001 << a;
            writedata  = {4{wdata[7:0]}};
            rdata_ext  = {{24{sign_ext & sel_b[7]}}, sel_b};
         end
         SIZE_H: begin
            byteenable = a[1] ? 4'b1100 : 4'b0011;
            writedata  = {2{wdata[15:0]}};
            rdata_ext  = {{16{sign_ext & sel_h[15]}}, sel_h};
            misaligned = a[0];
         end
         SIZE_W: begin
            byteenable = 4'b1111;
            writedata  = wdata;
            rdata_ext  = rdata_bus;
            misaligned = (a != 2'b00);
         end
         default: misaligned = 1'b1;
      endcase
   end

endmodule

// File: rtl/mips_bus_mem_unit.sv
// Serialises instruction-fetch and data load/store requests onto one Avalon-MM
// master port, with fixed/alternating arbitration and an optional waitrequest timeout.
module mips_bus_mem_unit
   import mips_bus_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int ARB_MODE = ARB_FIXED,
   parameter int MAX_WAIT = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_ack,
   output logic [31:0]         if_rdata,
   output logic                if_err,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [1:0]          d_size,
   input  logic                d_signed,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [31:0]         d_wdata,
   output logic                d_ack,
   output logic [31:0]         d_rdata,
   output logic                d_err,
   output logic                busy,
   output bus_state_t          dbg_state,
   mips_bus_mem_unit_if.master bus
);

   localparam int WCW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
   localparam logic [WCW-1:0] WAIT_LAST = WCW'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);
   localparam logic [WCW-1:0] WAIT_MAX  = WCW'(MAX_WAIT);

   bus_state_t        state_q, state_d;
   logic              chan_d_q, we_q, signed_q, err_q, favor_d_q;
   logic [1:0]        size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q, rdata_q;
   logic [WCW-1:0]    wait_cnt_q;

   logic              in_idle, in_bus, in_done;
   logic              contended, grant_any, grant_d, timeout;
   logic [ADDR_W-1:0] g_addr;
   logic [1:0]        g_size;
   logic              g_we, g_signed;
   logic [31:0]       g_wdata;
   logic [1:0]        la_size, la_a;
   logic              la_signed, la_misaligned;
   logic [31:0]       la_wdata, la_wd_rep, la_rdata;
   logic [3:0]        la_be;

   assign in_idle = (state_q == IDLE);
   assign in_bus  = (state_q == BUS);
   assign in_done = (state_q == DONE);

   // favor_d_q names the channel that wins the next contended grant.
   assign contended = if_req & d_req;
   assign grant_any = if_req | d_req;
   assign grant_d   = d_req & (~if_req | (ARB_MODE == ARB_FIXED) | favor_d_q);

   assign g_addr   = grant_d ? d_addr : if_addr;
   assign g_size   = grant_d ? d_size : SIZE_W;
   assign g_we     = grant_d & d_we;
   assign g_signed = grant_d & d_signed;
   assign g_wdata  = grant_d ? d_wdata : 32'd0;

   // The aligner checks the incoming request in IDLE and serves the latched access afterwards.
   assign la_size   = in_idle ? g_size        : size_q;
   assign la_a      = in_idle ? g_addr[1:0]   : addr_q[1:0];
   assign la_signed = in_idle ? g_signed      : signed_q;
   assign la_wdata  = in_idle ? g_wdata       : wdata_q;

   mips_bus_lane_align u_lane (
      .size       (la_size),
      .a          (la_a),
      .sign_ext   (la_signed),
      .wdata      (la_wdata),
      .rdata_bus  (bus.readdata),
      .byteenable (la_be),
      .writedata  (la_wd_rep),
      .rdata_ext  (la_rdata),
      .misaligned (la_misaligned)
   );

   assign timeout = (MAX_WAIT > 0) && bus.waitrequest && (wait_cnt_q == WAIT_LAST);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (grant_any) state_d = la_misaligned ? DONE : BUS;
         BUS:     if (!bus.waitrequest || timeout) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         chan_d_q   <= 1'b0;
         we_q       <= 1'b0;
         signed_q   <= 1'b0;
         err_q      <= 1'b0;
         favor_d_q  <= 1'b1;
         size_q     <= 2'b00;
         addr_q     <= '0;
         wdata_q    <= 32'd0;
         rdata_q    <= 32'd0;
         wait_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: if (grant_any) begin
               chan_d_q   <= grant_d;
               addr_q     <= g_addr;
               size_q     <= g_size;
               signed_q   <= g_signed;
               we_q       <= g_we;
               wdata_q    <= g_wdata;
               rdata_q    <= 32'd0;
               err_q      <= la_misaligned;
               wait_cnt_q <= '0;
               if (contended) favor_d_q <= ~grant_d;
            end
            BUS: begin
               if (!bus.waitrequest) begin
                  rdata_q <= we_q ? 32'd0 : la_rdata;
                  err_q   <= 1'b0;
               end else begin
                  if (wait_cnt_q != WAIT_MAX) wait_cnt_q <= wait_cnt_q + 1'b1;
                  if (timeout) begin
                     rdata_q <= 32'd0;
                     err_q   <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Bus strobes decode straight from state so an async reset drops them at once.
   assign bus.read       = in_bus & ~we_q;
   assign bus.write      = in_bus & we_q;
   assign bus.address    = in_bus ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
   assign bus.byteenable = in_bus ? la_be : 4'b0000;
   assign bus.writedata  = (in_bus & we_q) ? la_wd_rep : 32'd0;

   assign if_ack    = in_done & ~chan_d_q;
   assign d_ack     = in_done & chan_d_q;
   assign if_rdata  = if_ack ? rdata_q : 32'd0;
   assign d_rdata   = d_ack ? rdata_q : 32'd0;
   assign if_err    = if_ack & err_q;
   assign d_err     = d_ack & err_q;
   assign busy      = ~in_idle;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_mips_bus_mem_unit.sv
// Scoreboard bench for mips_bus_mem_unit: instance 0 uses fixed arbitration without timeout,
// instance 1 alternating arbitration with MAX_WAIT=5. Directed vectors, decoupled monitors.
`timescale 1ns/1ps
module tb_mips_bus_mem_unit;
   import mips_bus_pkg::*;

   localparam int AW = 32;

   typedef struct packed {
      logic        d;
      logic        err;
      logic [31:0] rdata;
   } ack_exp_t;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [7:0]  cycles;
   } bus_exp_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic          if_req[2];
   logic [AW-1:0] if_addr[2];
   logic          if_ack[2];
   logic [31:0]   if_rdata[2];
   logic          if_err[2];
   logic          d_req[2];
   logic          d_we[2];
   logic [1:0]    d_size[2];
   logic          d_signed[2];
   logic [AW-1:0] d_addr[2];
   logic [31:0]   d_wdata[2];
   logic          d_ack[2];
   logic [31:0]   d_rdata[2];
   logic          d_err[2];
   logic          busy[2];
   bus_state_t    dbg_state[2];

   int          stall_cfg[2];
   logic [31:0] rd_cfg[2];
   int          abort_cycles[2];

   ack_exp_t exp_ack_q[2][$];
   bus_exp_t exp_bus_q[2][$];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- DUTs, slave models, monitors ----------------
   for (genvar g = 0; g < 2; g++) begin : inst
      mips_bus_mem_unit_if #(.ADDR_W(AW)) bus_if ();

      mips_bus_mem_unit #(.ADDR_W(AW), .ARB_MODE(g), .MAX_WAIT(g * 5)) dut (
         .clk       (clk),
         .reset     (reset),
         .if_req    (if_req[g]),
         .if_addr   (if_addr[g]),
         .if_ack    (if_ack[g]),
         .if_rdata  (if_rdata[g]),
         .if_err    (if_err[g]),
         .d_req     (d_req[g]),
         .d_we      (d_we[g]),
         .d_size    (d_size[g]),
         .d_signed  (d_signed[g]),
         .d_addr    (d_addr[g]),
         .d_wdata   (d_wdata[g]),
         .d_ack     (d_ack[g]),
         .d_rdata   (d_rdata[g]),
         .d_err     (d_err[g]),
         .busy      (busy[g]),
         .dbg_state (dbg_state[g]),
         .bus       (bus_if)
      );

      int          stall_seen = 0;
      logic        prev_act = 1'b0;
      logic [31:0] prev_addr;
      logic [36:0] prev_ctl;
      int          act_cycles = 0;
      bus_exp_t    be_e;
      ack_exp_t    ak_e;

      initial begin
         bus_if.waitrequest = 1'b1;
         bus_if.readdata    = 32'hBAD0_BAD0;
      end

      // Slave: stalls stall_cfg cycles per access; waitrequest parked high when idle.
      always @(posedge clk) begin
         #1;
         if (bus_if.read || bus_if.write) begin
            bus_if.waitrequest = (stall_seen < stall_cfg[g]);
            bus_if.readdata    = bus_if.waitrequest ? 32'hBAD0_BAD0 : rd_cfg[g];
            stall_seen++;
         end else begin
            stall_seen         = 0;
            bus_if.waitrequest = 1'b1;
            bus_if.readdata    = 32'hBAD0_BAD0;
         end
      end

      // Bus monitor: stability while stalled, contents and length of each completed beat.
      always @(negedge clk) begin
         if (bus_if.read || bus_if.write) begin
            act_cycles++;
            check($sformatf("i%0d_rw_exclusive", g), 64'(bus_if.read & bus_if.write), 64'd0);
            if (prev_act) begin
               check($sformatf("i%0d_hold_addr", g), 64'(bus_if.address), 64'(prev_addr));
               check($sformatf("i%0d_hold_ctl", g),
                     64'({bus_if.write, bus_if.byteenable, bus_if.writedata}), 64'(prev_ctl));
            end
            if (!bus_if.waitrequest) begin
               if (exp_bus_q[g].size() == 0) begin
                  check($sformatf("i%0d_bus_unexpected", g), 64'd1, 64'd0);
               end else begin
                  be_e = exp_bus_q[g].pop_front();
                  check($sformatf("i%0d_bus_we", g), 64'(bus_if.write), 64'(be_e.we));
                  check($sformatf("i%0d_bus_addr", g), 64'(bus_if.address), 64'(be_e.addr));
                  check($sformatf("i%0d_bus_be", g), 64'(bus_if.byteenable), 64'(be_e.be));
                  if (be_e.we)
                     check($sformatf("i%0d_bus_wdata", g), 64'(bus_if.writedata), 64'(be_e.wdata));
                  check($sformatf("i%0d_bus_cycles", g), 64'(act_cycles), 64'(be_e.cycles));
               end
               act_cycles = 0;
            end
         end else if (prev_act) begin
            abort_cycles[g] = act_cycles;
            act_cycles      = 0;
         end
         prev_act  = (bus_if.read || bus_if.write) && bus_if.waitrequest;
         prev_addr = bus_if.address;
         prev_ctl  = {bus_if.write, bus_if.byteenable, bus_if.writedata};
      end

      // Ack monitor: every completion pulse pops one expected response in order.
      always @(negedge clk) begin
         if (if_ack[g] || d_ack[g]) begin
            check($sformatf("i%0d_ack_exclusive", g), 64'(if_ack[g] & d_ack[g]), 64'd0);
            if (exp_ack_q[g].size() == 0) begin
               check($sformatf("i%0d_ack_unexpected", g), 64'd1, 64'd0);
            end else begin
               ak_e = exp_ack_q[g].pop_front();
               check($sformatf("i%0d_ack_chan", g), 64'(d_ack[g]), 64'(ak_e.d));
               if (ak_e.d) begin
                  check($sformatf("i%0d_d_err", g), 64'(d_err[g]), 64'(ak_e.err));
                  check($sformatf("i%0d_d_rdata", g), 64'(d_rdata[g]), 64'(ak_e.rdata));
               end else begin
                  check($sformatf("i%0d_if_err", g), 64'(if_err[g]), 64'(ak_e.err));
                  check($sformatf("i%0d_if_rdata", g), 64'(if_rdata[g]), 64'(ak_e.rdata));
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic push_ack(input int i, input logic is_d, input logic err, input logic [31:0] rd);
      ack_exp_t a;
      a.d = is_d; a.err = err; a.rdata = rd;
      exp_ack_q[i].push_back(a);
   endtask

   task automatic push_bus(input int i, input logic we, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wd, input int cyc);
      bus_exp_t b;
      b.we = we; b.addr = addr; b.be = be; b.wdata = wd; b.cycles = 8'(cyc);
      exp_bus_q[i].push_back(b);
   endtask

   task automatic wait_ack(input int i, input logic is_d, input int limit, output int lat);
      logic got;
      got = 1'b0;
      lat = 0;
      while (!got && lat < limit) begin
         @(posedge clk); #1;
         lat++;
         got = is_d ? d_ack[i] : if_ack[i];
      end
   endtask

   task automatic access(input int i, input logic is_d, input logic we, input logic [1:0] size,
                         input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rbus, input int stall, input logic exp_err,
                         input logic [31:0] exp_rd, input logic exp_bus, input logic [3:0] exp_be,
                         input logic [31:0] exp_wd, input int exp_lat, input string name);
      int lat;
      stall_cfg[i] = stall;
      rd_cfg[i]    = rbus;
      push_ack(i, is_d, exp_err, exp_rd);
      if (exp_bus) push_bus(i, we, {addr[31:2], 2'b00}, exp_be, exp_wd, stall + 1);
      if (is_d) begin
         d_we[i] = we; d_size[i] = size; d_signed[i] = sgn; d_addr[i] = addr; d_wdata[i] = wdata;
         d_req[i] = 1'b1;
      end else begin
         if_addr[i] = addr;
         if_req[i]  = 1'b1;
      end
      wait_ack(i, is_d, 60, lat);
      check({name, "_latency"}, 64'(lat), 64'(exp_lat));
      d_req[i]  = 1'b0;
      if_req[i] = 1'b0;
      @(posedge clk); #1;
   endtask

   // order bit k = 1 means the k-th grant is expected on the data channel.
   task automatic contend(input int i, input logic [7:0] order, input string name);
      int di, fi, lat_d, lat_f;
      di = 0; fi = 0;
      stall_cfg[i] = 0;
      rd_cfg[i]    = 32'h1357_9BDF;
      for (int k = 0; k < 8; k++) begin
         if (order[k]) begin
            push_ack(i, 1'b1, 1'b0, 32'h1357_9BDF);
            push_bus(i, 1'b0, 32'h600 + 32'(di * 4), 4'b1111, 32'd0, 1);
            di++;
         end else begin
            push_ack(i, 1'b0, 1'b0, 32'h1357_9BDF);
            push_bus(i, 1'b0, 32'h700 + 32'(fi * 4), 4'b1111, 32'd0, 1);
            fi++;
         end
      end
      d_we[i] = 1'b0; d_size[i] = SIZE_W; d_signed[i] = 1'b0; d_wdata[i] = 32'd0;
      fork
         begin
            for (int k = 0; k < 4; k++) begin
               d_addr[i] = 32'h600 + 32'(k * 4);
               d_req[i]  = 1'b1;
               wait_ack(i, 1'b1, 80, lat_d);
               check({name, "_d_done"}, 64'(d_ack[i]), 64'd1);
            end
            d_req[i] = 1'b0;
         end
         begin
            for (int k = 0; k < 4; k++) begin
               if_addr[i] = 32'h700 + 32'(k * 4);
               if_req[i]  = 1'b1;
               wait_ack(i, 1'b0, 80, lat_f);
               check({name, "_f_done"}, 64'(if_ack[i]), 64'd1);
            end
            if_req[i] = 1'b0;
         end
      join
      @(posedge clk); #1;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      for (int i = 0; i < 2; i++) begin
         if_req[i] = 1'b0; if_addr[i] = '0;
         d_req[i] = 1'b0; d_we[i] = 1'b0; d_size[i] = SIZE_W; d_signed[i] = 1'b0;
         d_addr[i] = '0; d_wdata[i] = 32'd0;
         stall_cfg[i] = 0; rd_cfg[i] = 32'd0; abort_cycles[i] = 0;
      end
      repeat (3) @(posedge clk);
      #2;
      check("i0_rst_bus_ctl", 64'({inst[0].bus_if.read, inst[0].bus_if.write, inst[0].bus_if.byteenable,
                                   inst[0].bus_if.writedata}), 64'd0);
      check("i0_rst_bus_addr", 64'(inst[0].bus_if.address), 64'd0);
      check("i1_rst_bus_ctl", 64'({inst[1].bus_if.read, inst[1].bus_if.write, inst[1].bus_if.byteenable,
                                   inst[1].bus_if.writedata}), 64'd0);
      check("i1_rst_bus_addr", 64'(inst[1].bus_if.address), 64'd0);
      for (int i = 0; i < 2; i++) begin
         check("rst_core_ctl", 64'({if_ack[i], if_err[i], d_ack[i], d_err[i], busy[i], dbg_state[i]}), 64'd0);
         check("rst_core_data", {if_rdata[i], d_rdata[i]}, 64'd0);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;

      // instance 0: fixed arbitration, no timeout
      access(0, 0, 0, SIZE_W, 0, 32'h104, 32'd0, 32'h2402_0005, 0, 0, 32'h2402_0005, 1, 4'b1111, 32'd0, 2, "fetch_104");
      access(0, 1, 0, SIZE_B, 1, 32'h103, 32'd0, 32'h80FF_1234, 0, 0, 32'hFFFF_FF80, 1, 4'b1000, 32'd0, 2, "lb_103");
      access(0, 1, 0, SIZE_B, 0, 32'h103, 32'd0, 32'h80FF_1234, 0, 0, 32'h0000_0080, 1, 4'b1000, 32'd0, 2, "lbu_103");
      access(0, 1, 0, SIZE_B, 1, 32'h102, 32'd0, 32'h80FF_1234, 0, 0, 32'hFFFF_FFFF, 1, 4'b0100, 32'd0, 2, "lb_102");
      access(0, 1, 0, SIZE_B, 1, 32'h101, 32'd0, 32'h80FF_1234, 0, 0, 32'h0000_0012, 1, 4'b0010, 32'd0, 2, "lb_101");
      access(0, 1, 0, SIZE_H, 1, 32'h002, 32'd0, 32'h80FF_1234, 0, 0, 32'hFFFF_80FF, 1, 4'b1100, 32'd0, 2, "lh_002");
      access(0, 1, 0, SIZE_H, 0, 32'h000, 32'd0, 32'h80FF_1234, 0, 0, 32'h0000_1234, 1, 4'b0011, 32'd0, 2, "lhu_000");
      access(0, 1, 1, SIZE_H, 0, 32'h202, 32'h0000_ABCD, 32'd0, 3, 0, 32'd0, 1, 4'b1100, 32'hABCD_ABCD, 5, "sh_202");
      access(0, 1, 1, SIZE_B, 0, 32'h101, 32'h1234_565A, 32'd0, 0, 0, 32'd0, 1, 4'b0010, 32'h5A5A_5A5A, 2, "sb_101");
      access(0, 1, 1, SIZE_W, 0, 32'h300, 32'hDEAD_BEEF, 32'd0, 0, 0, 32'd0, 1, 4'b1111, 32'hDEAD_BEEF, 2, "sw_300");
      access(0, 1, 0, SIZE_W, 0, 32'h006, 32'd0, 32'h1111_1111, 0, 1, 32'd0, 0, 4'b0000, 32'd0, 1, "lw_006_mis");
      access(0, 1, 1, SIZE_H, 0, 32'h201, 32'h0000_BEEF, 32'd0, 0, 1, 32'd0, 0, 4'b0000, 32'd0, 1, "sh_201_mis");
      access(0, 1, 0, 2'b11, 0, 32'h000, 32'd0, 32'h1111_1111, 0, 1, 32'd0, 0, 4'b0000, 32'd0, 1, "size11_mis");
      access(0, 0, 0, SIZE_W, 0, 32'h102, 32'd0, 32'h1111_1111, 0, 1, 32'd0, 0, 4'b0000, 32'd0, 1, "fetch_102_mis");
      access(0, 0, 0, SIZE_W, 0, 32'h010, 32'd0, 32'h0BAD_F00D, 2, 0, 32'h0BAD_F00D, 1, 4'b1111, 32'd0, 4, "fetch_stall2");
      contend(0, 8'b0000_1111, "arb_fixed");

      // instance 1: alternating arbitration, MAX_WAIT = 5
      contend(1, 8'b0101_0101, "arb_alt");
      access(1, 1, 0, SIZE_W, 0, 32'h006, 32'd0, 32'h1111_1111, 0, 1, 32'd0, 0, 4'b0000, 32'd0, 1, "i1_lw_006_mis");
      access(1, 1, 0, SIZE_W, 0, 32'h010, 32'd0, 32'hCAFE_F00D, 4, 0, 32'hCAFE_F00D, 1, 4'b1111, 32'd0, 6, "i1_lw_stall4");
      abort_cycles[1] = 0;
      access(1, 0, 0, SIZE_W, 0, 32'h400, 32'd0, 32'h2222_2222, 100, 1, 32'd0, 0, 4'b0000, 32'd0, 6, "i1_fetch_timeout");
      check("i1_fetch_timeout_read_cycles", 64'(abort_cycles[1]), 64'd5);
      abort_cycles[1] = 0;
      access(1, 1, 1, SIZE_W, 0, 32'h404, 32'h5555_AAAA, 32'd0, 100, 1, 32'd0, 0, 4'b0000, 32'd0, 6, "i1_sw_timeout");
      check("i1_sw_timeout_write_cycles", 64'(abort_cycles[1]), 64'd5);
      access(1, 0, 0, SIZE_W, 0, 32'h408, 32'd0, 32'h3C01_0010, 0, 0, 32'h3C01_0010, 1, 4'b1111, 32'd0, 2, "i1_fetch_after_to");

      // reset while instance 0 is stalled in BUS
      stall_cfg[0] = 100;
      if_addr[0]   = 32'h500;
      if_req[0]    = 1'b1;
      repeat (3) @(posedge clk);
      #3;
      check("pre_reset_read", 64'(inst[0].bus_if.read), 64'd1);
      reset = 1'b0;
      #1;
      check("reset_read_drop", 64'(inst[0].bus_if.read), 64'd0);
      check("reset_busy", 64'(busy[0]), 64'd0);
      if_req[0] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      access(0, 0, 0, SIZE_W, 0, 32'h104, 32'd0, 32'h2402_0005, 0, 0, 32'h2402_0005, 1, 4'b1111, 32'd0, 2, "fetch_after_reset");

      repeat (3) @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         check("ack_queue_drained", 64'(exp_ack_q[i].size()), 64'd0);
         check("bus_queue_drained", 64'(exp_bus_q[i].size()), 64'd0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mips_bus_mem_unit.md
# mips_bus_mem_unit

Avalon-MM bus master that serialises the MIPS core's instruction-fetch and data load/store requests onto the single shared memory bus. It generates byte enables and lane-replicated write data for byte, half and word accesses, and extracts and sign/zero-extends load data. It adds selectable fetch/data arbitration and a waitrequest timeout. It sits between the multi-cycle core datapath and the top-level Avalon ports of `mips_cpu_bus`.

## Interface
- `ADDR_W`, 32: byte-address width, ≥ 3.
- `ARB_MODE`, 0: 0 = data always beats fetch; 1 = alternate when both are pending.
- `MAX_WAIT`, 0: number of waitrequest-high cycles before an abort; 0 disables the timeout.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `if_req` input 1: fetch request, held until `if_ack`.
- `if_addr` input ADDR_W: fetch byte address; always a word access.
- `if_ack` output 1: one-cycle completion pulse.
- `if_rdata` output 32: instruction word, valid with `if_ack`.
- `if_err` output 1: with `if_ack`; misaligned fetch or timeout.
- `d_req` input 1: data request, held until `d_ack`.
- `d_we` input 1: 1 = store, 0 = load.
- `d_size` input 2: 00 = byte, 01 = half, 10 = word; 11 is treated as misaligned.
- `d_signed` input 1: sign-extend load result.
- `d_addr` input ADDR_W: data byte address.
- `d_wdata` input 32: store data, right-justified.
- `d_ack` output 1: one-cycle completion pulse.
- `d_rdata` output 32: extended load result, valid with `d_ack`; 0 for stores.
- `d_err` output 1: with `d_ack`; misaligned access or timeout.
- `busy` output 1: high in any state other than IDLE.
- `address` output ADDR_W: word-aligned bus address; bits [1:0] are always 0.
- `read` output 1: Avalon read.
- `write` output 1: Avalon write.
- `waitrequest` input 1: Avalon stall.
- `writedata` output 32: Avalon write data.
- `byteenable` output 4: Avalon lane enables.
- `readdata` input 32: Avalon read data, valid in the cycle where `read`=1 and `waitrequest`=0.

## Operation
States: IDLE, BUS, DONE.

IDLE:
- If neither request is present, stay in IDLE.
- If one request is present, grant it.
- If both are present and `ARB_MODE`=0, grant data.
- If both are present and `ARB_MODE`=1, grant the channel that did not win the last contended grant. The last-winner pointer updates only on contended grants; after reset it favours data.
- On grant, latch address, size, signedness, write flag and write data.

Misalignment:
- Misaligned cases: half with addr[0]=1; word with addr[1:0]≠0; `d_size`=11.
- A misaligned grant skips BUS and goes straight to DONE with err=1, rdata=0.
- No bus cycle is issued.

BUS:
- Drive `read` or `write`, `address`={addr[ADDR_W-1:2],2'b00}, `byteenable` and `writedata`.
- Hold all of them stable while `waitrequest`=1.
- At the edge where `waitrequest`=0:
  - capture and extract `readdata`;
  - drop `read`/`write`;
  - go to DONE.
- Timeout: if `MAX_WAIT`>0 and the wait counter reaches `MAX_WAIT` with `waitrequest` still 1, drop `read`/`write` and go to DONE with err=1, rdata=0.

DONE:
- Pulse the granted channel's ack (with rdata and err) for exactly one cycle, then go to IDLE.
- Requests are not sampled in DONE, so a still-asserted request is never re-accepted.

Lane rules (little-endian, a = addr[1:0]):
- Byte: `byteenable`=1<<a; `writedata`={4{wdata[7:0]}}.
- Half: `byteenable`=a[1]?1100:0011; `writedata`={2{wdata[15:0]}}.
- Word: `byteenable`=1111; `writedata`=wdata.
- Load: select lane(s) by a; zero-extend, or sign-extend when `d_signed`.
- The fetch channel ignores `d_signed`.

## Timing
- Reset (asynchronous, immediate):
  - state ← IDLE;
  - all outputs ← 0;
  - wait counter ← 0;
  - arbitration pointer ← data.
- Reset asserted during BUS drops `read`/`write` combinationally. The aborted request receives no ack; the requester re-issues it after reset.
- Latency:
  - Request sampled at edge N.
  - `read`/`write` high in cycle N+1.
  - With zero wait, ack in cycle N+2.
  - Next grant possible at edge N+3.
  - Each waitrequest cycle adds one cycle.
- Misaligned: ack in cycle N+1.
- Wait counter:
  - cleared on entry to BUS;
  - increments on each `waitrequest`=1 edge in BUS;
  - width is $clog2(MAX_WAIT+1);
  - saturates and never wraps.
- `waitrequest` is ignored outside BUS.
- Never `read` and `write` simultaneously.

## Structure
- Package `mips_bus_pkg` holds:
  - state enum `bus_state_t`;
  - size constants `SIZE_B`/`SIZE_H`/`SIZE_W`;
  - arbitration constants `ARB_FIXED`/`ARB_ALT`.
- Sub-module `mips_bus_lane_align` (combinational):
  - computes byteenable, replicated writedata, load extraction/extension and the misaligned flag from size, a, signed and data;
  - instantiated once.

## Test plan
- Fetch 0x0000_0104, waitrequest=0, readdata=0x2402_0005 -> address=0x104, read=1 for 1 cycle, `if_ack` 2 cycles after request, `if_rdata`=0x2402_0005, `if_err`=0.
- Signed byte load 0x103, readdata=0x80FF_1234 -> byteenable=1000, `d_rdata`=0xFFFF_FF80; the same access unsigned -> 0x0000_0080.
- Half store 0x202 with wdata 0xABCD, waitrequest high 3 cycles -> write=1 for 4 cycles with stable signals, writedata=0xABCD_ABCD, byteenable=1100, one `d_ack`.
- `d_req` and `if_req` both held, 4 accesses each:
  - `ARB_MODE`=0 -> all data accesses first;
  - `ARB_MODE`=1 -> grants alternate D,F,D,F.
- Word load 0x006 -> no read issued, `d_ack`=1 with `d_err`=1 one cycle after the request; with `MAX_WAIT`=5 and waitrequest stuck high -> read drops after 5 stalled cycles, ack with err=1, rdata=0.
- Reset pulled low during BUS with waitrequest high -> read=0 immediately, busy=0, no ack; after release a new fetch completes normally.
